// File: rtl/mc_defs.sv
// Shared definitions for the multi-cycle MIPS control unit: ALU codes,
// FSM state codes, opcode/funct values, datapath select codes and the
// instruction class captured in DECODE.
package mc_defs;

  // ALU operation codes
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLLV = 3'b101;

  // FSM state codes (11-15 are unused)
  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_EXEC_R   = 4'd2,
    ST_EXEC_I   = 4'd3,
    ST_MEM_ADDR = 4'd4,
    ST_MEM_RD   = 4'd5,
    ST_MEM_WR   = 4'd6,
    ST_MEM_WB   = 4'd7,
    ST_ALU_WB   = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JUMP     = 4'd10
  } state_t;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;

  // ALU operand A select
  localparam logic [1:0] SRCA_PC   = 2'b00;
  localparam logic [1:0] SRCA_REGA = 2'b01;
  localparam logic [1:0] SRCA_C16  = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PC_ALU     = 2'b00;
  localparam logic [1:0] PC_ALUOUT  = 2'b01;
  localparam logic [1:0] PC_REGA    = 2'b10;
  localparam logic [1:0] PC_JTARGET = 2'b11;

  // Destination register select
  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  // Register write-back data select
  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  // Instruction class held from DECODE until the next FETCH
  typedef enum logic [3:0] {
    OC_RTYPE,
    OC_ORI,
    OC_LUI,
    OC_LW,
    OC_SW,
    OC_BEQ,
    OC_J,
    OC_JAL,
    OC_JR,
    OC_NOP
  } opclass_t;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Bundle between the control FSM and the shared datapath: instruction
// fields and status flags in, mux selects and write enables out.
interface mc_control_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       ALUzero;
  logic       imemReady;
  logic       dmemReady;
  logic [2:0] ALUctrl;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ExtOp;
  logic       PCwrite;
  logic [1:0] PCsrc;
  logic       IRwrite;
  logic       MemWrite;
  logic       RegWrite;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic       illegal;
  logic [3:0] state;

  // Control unit side
  modport master (
    input  opcode, funct, ALUzero, imemReady, dmemReady,
    output ALUctrl, ALUSrcA, ALUSrcB, ExtOp, PCwrite, PCsrc, IRwrite,
           MemWrite, RegWrite, RegDst, MemtoReg, illegal, state
  );

  // Datapath side
  modport slave (
    output opcode, funct, ALUzero, imemReady, dmemReady,
    input  ALUctrl, ALUSrcA, ALUSrcB, ExtOp, PCwrite, PCsrc, IRwrite,
           MemWrite, RegWrite, RegDst, MemtoReg, illegal, state
  );
endinterface

// File: rtl/mc_decode.sv
// Instruction classifier: maps opcode/funct to an instruction class and
// the ALU operation an R-type instruction needs. Unknown encodings map
// to OC_NOP, which the FSM reports as illegal.
module mc_decode
  import mc_defs::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output opclass_t   op_class,
  output logic [2:0] alu_ctrl
);

  // Pure lookup of the instruction class and R-type ALU operation
  always_comb begin
    op_class = OC_NOP;
    alu_ctrl = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: begin op_class = OC_RTYPE; alu_ctrl = ALU_ADD;  end
          FN_SUBU: begin op_class = OC_RTYPE; alu_ctrl = ALU_SUB;  end
          FN_AND:  begin op_class = OC_RTYPE; alu_ctrl = ALU_AND;  end
          FN_OR:   begin op_class = OC_RTYPE; alu_ctrl = ALU_OR;   end
          FN_XOR:  begin op_class = OC_RTYPE; alu_ctrl = ALU_XOR;  end
          FN_SLLV: begin op_class = OC_RTYPE; alu_ctrl = ALU_SLLV; end
          FN_JR:   op_class = OC_JR;
          default: op_class = OC_NOP;
        endcase
      end
      OP_ORI:  op_class = OC_ORI;
      OP_LUI:  op_class = OC_LUI;
      OP_LW:   op_class = OC_LW;
      OP_SW:   op_class = OC_SW;
      OP_BEQ:  op_class = OC_BEQ;
      OP_J:    op_class = OC_J;
      OP_JAL:  op_class = OC_JAL;
      default: op_class = OC_NOP;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control unit. Walks each instruction through
// FETCH/DECODE/EXEC/MEM/WB, holding in FETCH and the memory states until
// the matching ready flag arrives. Outputs are Moore-style, decoded from
// the state and the instruction class latched in DECODE; only the branch
// PC write looks at ALUzero directly.
module mc_control_fsm
  import mc_defs::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0,
  parameter logic [1:0] JAL_REG     = RD_RA
) (
  input  logic           clk,
  input  logic           reset,
  mc_control_fsm_if.master bus
);

  state_t     state_q, state_d;
  opclass_t   op_class_q, dec_class;
  logic [2:0] r_alu_q, dec_alu;

  logic [2:0] alu_ctrl;
  logic [1:0] src_a, src_b, pc_src, reg_dst, mem_to_reg;
  logic       ext_op, pc_write, ir_write, mem_write, reg_write, illegal;

  mc_decode u_decode (
    .opcode   (bus.opcode),
    .funct    (bus.funct),
    .op_class (dec_class),
    .alu_ctrl (dec_alu)
  );

  // State register; the instruction class and R-type ALU op are captured in DECODE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= state_t'(RESET_STATE);
      op_class_q <= OC_NOP;
      r_alu_q    <= ALU_ADD;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) begin
        op_class_q <= dec_class;
        r_alu_q    <= dec_alu;
      end
    end
  end

  // Next-state and output decode; reset overrides every write enable
  always_comb begin
    state_d    = ST_FETCH;
    alu_ctrl   = ALU_AND;
    src_a      = SRCA_PC;
    src_b      = SRCB_REGB;
    ext_op     = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_ALU;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = RD_RT;
    mem_to_reg = M2R_ALUOUT;
    illegal    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        src_a    = SRCA_PC;
        src_b    = SRCB_FOUR;
        alu_ctrl = ALU_ADD;
        pc_src   = PC_ALU;
        ir_write = bus.imemReady;
        pc_write = bus.imemReady;
        state_d  = bus.imemReady ? ST_DECODE : ST_FETCH;
      end
      ST_DECODE: begin
        src_a    = SRCA_PC;
        src_b    = SRCB_IMM_SH;
        ext_op   = 1'b1;
        alu_ctrl = ALU_ADD;
        case (dec_class)
          OC_RTYPE:           state_d = ST_EXEC_R;
          OC_J, OC_JAL, OC_JR: state_d = ST_JUMP;
          OC_ORI, OC_LUI:     state_d = ST_EXEC_I;
          OC_LW, OC_SW:       state_d = ST_MEM_ADDR;
          OC_BEQ:             state_d = ST_BRANCH;
          default: begin
            illegal = 1'b1;
            state_d = ST_FETCH;
          end
        endcase
      end
      ST_EXEC_R: begin
        src_a    = SRCA_REGA;
        src_b    = SRCB_REGB;
        alu_ctrl = r_alu_q;
        state_d  = ST_ALU_WB;
      end
      ST_EXEC_I: begin
        src_b  = SRCB_IMM;
        ext_op = 1'b0;
        if (op_class_q == OC_LUI) begin
          src_a    = SRCA_C16;
          alu_ctrl = ALU_SLLV;
        end else begin
          src_a    = SRCA_REGA;
          alu_ctrl = ALU_OR;
        end
        state_d = ST_ALU_WB;
      end
      ST_ALU_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = M2R_ALUOUT;
        reg_dst    = (op_class_q == OC_RTYPE) ? RD_RD : RD_RT;
        state_d    = ST_FETCH;
      end
      ST_MEM_ADDR: begin
        src_a    = SRCA_REGA;
        src_b    = SRCB_IMM;
        ext_op   = 1'b1;
        alu_ctrl = ALU_ADD;
        state_d  = (op_class_q == OC_LW) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        state_d = bus.dmemReady ? ST_MEM_WB : ST_MEM_RD;
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        state_d   = bus.dmemReady ? ST_FETCH : ST_MEM_WR;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        reg_dst    = RD_RT;
        mem_to_reg = M2R_MDR;
        state_d    = ST_FETCH;
      end
      ST_BRANCH: begin
        src_a    = SRCA_REGA;
        src_b    = SRCB_REGB;
        alu_ctrl = ALU_SUB;
        pc_src   = PC_ALUOUT;
        pc_write = bus.ALUzero;
        state_d  = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write = 1'b1;
        case (op_class_q)
          OC_J: pc_src = PC_JTARGET;
          OC_JAL: begin
            pc_src     = PC_JTARGET;
            reg_write  = 1'b1;
            reg_dst    = JAL_REG;
            mem_to_reg = M2R_PC;
          end
          default: pc_src = PC_REGA;
        endcase
        state_d = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

  assign bus.ALUctrl  = alu_ctrl;
  assign bus.ALUSrcA  = src_a;
  assign bus.ALUSrcB  = src_b;
  assign bus.ExtOp    = ext_op;
  assign bus.PCwrite  = pc_write;
  assign bus.PCsrc    = pc_src;
  assign bus.IRwrite  = ir_write;
  assign bus.MemWrite = mem_write;
  assign bus.RegWrite = reg_write;
  assign bus.RegDst   = reg_dst;
  assign bus.MemtoReg = mem_to_reg;
  assign bus.illegal  = illegal;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for the multi-cycle control unit. A reference model turns one
// instruction plus its wait counts into the expected per-cycle output
// vectors and the ready/zero inputs to drive; each test task replays
// that plan and compares cycle by cycle.
module tb_mc_control_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] alu;
    logic [1:0] a;
    logic [1:0] b;
    logic       ext;
    logic       pcw;
    logic [1:0] pcs;
    logic       irw;
    logic       memw;
    logic       regw;
    logic [1:0] rd;
    logic [1:0] m2r;
    logic       ill;
  } outv_t;

  typedef struct packed {
    outv_t exp;
    logic  im;
    logic  dm;
    logic  z;
  } cyc_t;

  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   total = 0;
  cyc_t plan[$];

  mc_control_fsm_if bus();

  mc_control_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic outv_t blank(input logic [3:0] s);
    outv_t e;
    e = '0;
    e.st = s;
    return e;
  endfunction

  function automatic outv_t observe();
    outv_t o;
    o.st = bus.state;     o.alu = bus.ALUctrl;  o.a = bus.ALUSrcA;
    o.b = bus.ALUSrcB;    o.ext = bus.ExtOp;    o.pcw = bus.PCwrite;
    o.pcs = bus.PCsrc;    o.irw = bus.IRwrite;  o.memw = bus.MemWrite;
    o.regw = bus.RegWrite; o.rd = bus.RegDst;   o.m2r = bus.MemtoReg;
    o.ill = bus.illegal;
    return o;
  endfunction

  task automatic push(input outv_t e, input logic im, input logic dm, input logic z);
    cyc_t c;
    c.exp = e; c.im = im; c.dm = dm; c.z = z;
    plan.push_back(c);
  endtask

  // Instruction-set view: which class an encoding belongs to, and its ALU op
  task automatic classify(input logic [5:0] op, input logic [5:0] fn,
                          output string cls, output logic [2:0] alu);
    cls = "bad";
    alu = 3'b010;
    if (op == 6'b000000) begin
      case (fn)
        6'b100001: begin cls = "r"; alu = 3'b010; end
        6'b100011: begin cls = "r"; alu = 3'b011; end
        6'b100100: begin cls = "r"; alu = 3'b000; end
        6'b100101: begin cls = "r"; alu = 3'b001; end
        6'b100110: begin cls = "r"; alu = 3'b100; end
        6'b000100: begin cls = "r"; alu = 3'b101; end
        6'b001000: cls = "jr";
        default:   cls = "bad";
      endcase
    end else begin
      case (op)
        6'b001101: cls = "ori";
        6'b001111: cls = "lui";
        6'b100011: cls = "lw";
        6'b101011: cls = "sw";
        6'b000100: cls = "beq";
        6'b000010: cls = "j";
        6'b000011: cls = "jal";
        default:   cls = "bad";
      endcase
    end
  endtask

  // Reference model: expected cycle sequence of one instruction
  task automatic buildPlan(input logic [5:0] op, input logic [5:0] fn,
                           input int fw, input int mw, input logic z);
    string cls;
    logic [2:0] ralu;
    outv_t e;
    plan.delete();
    classify(op, fn, cls, ralu);
    for (int k = 0; k <= fw; k++) begin
      e = blank(4'd0); e.b = 2'b01; e.alu = 3'b010;
      e.irw = (k == fw); e.pcw = (k == fw);
      push(e, (k == fw), rb(), rb());
    end
    e = blank(4'd1); e.b = 2'b11; e.ext = 1'b1; e.alu = 3'b010;
    e.ill = (cls == "bad");
    push(e, rb(), rb(), rb());
    if (cls == "r" || cls == "ori" || cls == "lui") begin
      if (cls == "r") begin
        e = blank(4'd2); e.a = 2'b01; e.b = 2'b00; e.alu = ralu;
      end else if (cls == "ori") begin
        e = blank(4'd3); e.a = 2'b01; e.b = 2'b10; e.alu = 3'b001;
      end else begin
        e = blank(4'd3); e.a = 2'b10; e.b = 2'b10; e.alu = 3'b101;
      end
      push(e, rb(), rb(), rb());
      e = blank(4'd8); e.regw = 1'b1; e.rd = (cls == "r") ? 2'b01 : 2'b00;
      push(e, rb(), rb(), rb());
    end else if (cls == "lw" || cls == "sw") begin
      e = blank(4'd4); e.a = 2'b01; e.b = 2'b10; e.ext = 1'b1; e.alu = 3'b010;
      push(e, rb(), rb(), rb());
      for (int k = 0; k <= mw; k++) begin
        if (cls == "lw") e = blank(4'd5);
        else begin e = blank(4'd6); e.memw = 1'b1; end
        push(e, rb(), (k == mw), rb());
      end
      if (cls == "lw") begin
        e = blank(4'd7); e.regw = 1'b1; e.m2r = 2'b01;
        push(e, rb(), rb(), rb());
      end
    end else if (cls == "beq") begin
      e = blank(4'd9); e.a = 2'b01; e.alu = 3'b011; e.pcs = 2'b01; e.pcw = z;
      push(e, rb(), rb(), z);
    end else if (cls == "j" || cls == "jal" || cls == "jr") begin
      e = blank(4'd10); e.pcw = 1'b1;
      e.pcs = (cls == "jr") ? 2'b10 : 2'b11;
      if (cls == "jal") begin e.regw = 1'b1; e.rd = 2'b10; e.m2r = 2'b10; end
      push(e, rb(), rb(), rb());
    end
  endtask

  // Drive one cycle's inputs just after a falling edge, sample, advance
  task automatic stepCycle(input cyc_t c, output outv_t obs);
    bus.imemReady = c.im;
    bus.dmemReady = c.dm;
    bus.ALUzero   = c.z;
    #1;
    obs = observe();
    @(negedge clk);
  endtask

  task automatic test_reset();
    outv_t e;
    outv_t obs;
    e = blank(4'd0); e.b = 2'b01; e.alu = 3'b010;
    reset = 1'b1; bus.imemReady = 1'b1; bus.dmemReady = 1'b1;
    bus.ALUzero = 1'b0; bus.opcode = 6'd0; bus.funct = 6'd0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      #1; obs = observe(); total++;
      if (obs !== e) $display("[TB] FAIL reset_hold%0d: got %h want %h", i, obs, e);
      else passed++;
      @(negedge clk);
    end
    reset = 1'b0; bus.imemReady = 1'b0;
    #1; obs = observe(); total++;
    if (obs !== e) $display("[TB] FAIL reset_release: got %h want %h", obs, e);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_addu();
    outv_t obs;
    bus.opcode = 6'b000000; bus.funct = 6'b100001;
    buildPlan(bus.opcode, bus.funct, 0, 0, 1'b0);
    for (int i = 0; i < plan.size(); i++) begin
      stepCycle(plan[i], obs); total++;
      if (obs !== plan[i].exp) $display("[TB] FAIL addu_c%0d: got %h want %h", i, obs, plan[i].exp);
      else passed++;
    end
    bus.imemReady = 1'b0; #1; total++;
    if (bus.state !== 4'd0) $display("[TB] FAIL addu_end_state: got %0d want 0", bus.state);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_lw_wait();
    outv_t obs;
    int regw_count;
    regw_count = 0;
    bus.opcode = 6'b100011; bus.funct = 6'($urandom);
    buildPlan(bus.opcode, bus.funct, 0, 3, 1'b0);
    for (int i = 0; i < plan.size(); i++) begin
      stepCycle(plan[i], obs); total++;
      if (obs.regw === 1'b1 && obs.m2r === 2'b01) regw_count++;
      if (obs !== plan[i].exp) $display("[TB] FAIL lw_c%0d: got %h want %h", i, obs, plan[i].exp);
      else passed++;
    end
    total++;
    if (regw_count != 1) $display("[TB] FAIL lw_regwrite_count: got %0d want 1", regw_count);
    else passed++;
    bus.imemReady = 1'b0; #1; total++;
    if (bus.state !== 4'd0) $display("[TB] FAIL lw_end_state: got %0d want 0", bus.state);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_beq();
    outv_t obs;
    for (int r = 0; r < 2; r++) begin
      bus.opcode = 6'b000100; bus.funct = 6'($urandom);
      buildPlan(bus.opcode, bus.funct, 0, 0, (r == 0));
      for (int i = 0; i < plan.size(); i++) begin
        stepCycle(plan[i], obs); total++;
        if (obs !== plan[i].exp) $display("[TB] FAIL beq_z%0d_c%0d: got %h want %h", (r == 0), i, obs, plan[i].exp);
        else passed++;
      end
    end
    bus.imemReady = 1'b0; #1; total++;
    if (bus.state !== 4'd0) $display("[TB] FAIL beq_end_state: got %0d want 0", bus.state);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_lui();
    outv_t obs;
    bus.opcode = 6'b001111; bus.funct = 6'($urandom);
    buildPlan(bus.opcode, bus.funct, 1, 0, 1'b0);
    for (int i = 0; i < plan.size(); i++) begin
      stepCycle(plan[i], obs); total++;
      if (obs !== plan[i].exp) $display("[TB] FAIL lui_c%0d: got %h want %h", i, obs, plan[i].exp);
      else passed++;
    end
  endtask

  task automatic test_illegal();
    outv_t obs;
    bus.opcode = 6'b111111; bus.funct = 6'($urandom);
    buildPlan(bus.opcode, bus.funct, 0, 0, 1'b0);
    for (int i = 0; i < plan.size(); i++) begin
      stepCycle(plan[i], obs); total++;
      if (obs !== plan[i].exp) $display("[TB] FAIL illegal_c%0d: got %h want %h", i, obs, plan[i].exp);
      else passed++;
    end
    bus.imemReady = 1'b0; #1; total++;
    if (bus.state !== 4'd0 || bus.illegal !== 1'b0)
      $display("[TB] FAIL illegal_after: state %0d illegal %b want 0 0", bus.state, bus.illegal);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_sw();
    outv_t obs;
    outv_t e;
    bus.opcode = 6'b101011; bus.funct = 6'($urandom);
    buildPlan(bus.opcode, bus.funct, 0, 3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      stepCycle(plan[i], obs); total++;
      if (obs !== plan[i].exp) $display("[TB] FAIL swrst_c%0d: got %h want %h", i, obs, plan[i].exp);
      else passed++;
    end
    reset = 1'b1; bus.dmemReady = 1'b0; bus.imemReady = 1'b1;
    #1; obs = observe(); e = blank(4'd6); total++;
    if (obs !== e) $display("[TB] FAIL swrst_in_memwr: got %h want %h", obs, e);
    else passed++;
    @(negedge clk);
    #1; obs = observe(); e = blank(4'd0); e.b = 2'b01; e.alu = 3'b010; total++;
    if (obs !== e) $display("[TB] FAIL swrst_next: got %h want %h", obs, e);
    else passed++;
    @(negedge clk);
    reset = 1'b0; bus.imemReady = 1'b0;
    #1; obs = observe(); total++;
    if (obs !== e) $display("[TB] FAIL swrst_release: got %h want %h", obs, e);
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops[17] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                            6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03, 6'h3f, 6'h01};
    logic [5:0] fns[17] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h04, 6'h08, 6'h3f,
                            6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    outv_t obs;
    int idx;
    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, 16);
      bus.opcode = ops[idx];
      bus.funct = (ops[idx] == 6'h00) ? fns[idx] : 6'($urandom);
      buildPlan(bus.opcode, bus.funct, $urandom_range(0, 2), $urandom_range(0, 3), rb());
      for (int i = 0; i < plan.size(); i++) begin
        stepCycle(plan[i], obs); total++;
        if (obs !== plan[i].exp)
          $display("[TB] FAIL b2b_n%0d_op%h_fn%h_c%0d: got %h want %h", n, bus.opcode, bus.funct, i, obs, plan[i].exp);
        else passed++;
      end
    end
    bus.imemReady = 1'b0; #1; total++;
    if (bus.state !== 4'd0) $display("[TB] FAIL b2b_end_state: got %0d want 0", bus.state);
    else passed++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw_wait();
    test_beq();
    test_lui();
    test_illegal();
    test_reset_mid_sw();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle MIPS control unit.
- Produces the 3-bit ALU operation code and the datapath mux selects and write enables, and consumes the ALU zero flag.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states.
- Stalls on instruction-memory and data-memory ready handshakes.
- Sits between the IR/register file and the shared datapath (PC, IR, A/B, ALUOut, MDR registers).

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH).
- JAL_REG, 2'b10, RegDst code that selects register $31.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  6  IR[31:26]; stable from DECODE until return to FETCH.
- funct  in  6  IR[5:0].
- ALUzero  in  1  ALU result==0 flag, same cycle.
- imemReady  in  1  instruction word valid this cycle.
- dmemReady  in  1  data read/write completes this cycle.
- ALUctrl  out  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR, 101 B<<A.
- ALUSrcA  out  2  00 PC, 01 regA, 10 constant 16.
- ALUSrcB  out  2  00 regB, 01 constant 4, 10 ext imm, 11 ext imm<<2.
- ExtOp  out  1  1 sign-extend, 0 zero-extend.
- PCwrite  out  1  PC load enable.
- PCsrc  out  2  00 ALU result, 01 ALUOut, 10 regA, 11 {PC[31:28],imm26,2'b0}.
- IRwrite  out  1  IR load enable.
- MemWrite  out  1  data memory write strobe.
- RegWrite  out  1  register file write enable.
- RegDst  out  2  00 rt, 01 rd, 10 $31.
- MemtoReg  out  2  00 ALUOut, 01 MDR, 10 PC.
- illegal  out  1  one-cycle pulse on an undecodable instruction.
- state  out  4  current state, for debug.

Behaviour:
- Moore outputs decoded from state plus the registered opClass; only PCwrite in BRANCH depends combinationally on ALUzero.
- Any output not listed for a state is 0.
- Reset: synchronous; next state = FETCH and opClass = NOP. While reset is high, all enables (PCwrite, IRwrite, MemWrite, RegWrite) are forced to 0 and illegal=0.
- Reset mid-instruction abandons it; no partial writes occur after the reset edge.
- States: FETCH0, DECODE1, EXEC_R2, EXEC_I3, MEM_ADDR4, MEM_RD5, MEM_WR6, MEM_WB7, ALU_WB8, BRANCH9, JUMP10.
- FETCH:
  - Outputs: A=00, B=01, ADD, PCsrc=00; IRwrite=PCwrite=imemReady.
  - Stays in FETCH while imemReady=0. Goes to DECODE when it is 1.
- DECODE:
  - Outputs: A=00, B=11, ExtOp=1, ADD (branch target into ALUOut).
  - Registers opClass from opcode/funct.
  - R-type addu 100001, subu 100011, and 100100, or 100101, xor 100110, sllv 000100 → EXEC_R.
  - jr 001000, j 000010, jal 000011 → JUMP.
  - ori 001101, lui 001111 → EXEC_I.
  - lw 100011, sw 101011 → MEM_ADDR.
  - beq 000100 → BRANCH.
  - Anything else: illegal=1 for this cycle, → FETCH (treated as NOP; PC already advanced).
- EXEC_R: A=01, B=00, ALUctrl by funct (sllv→101, so rd = rt << rs). → ALU_WB.
- EXEC_I:
  - ori: A=01, B=10, ExtOp=0, OR.
  - lui: A=10, B=10, ExtOp=0, ALUctrl 101.
  - → ALU_WB.
- ALU_WB: RegWrite=1, MemtoReg=00; RegDst=01 for R-type, 00 for I-type. → FETCH.
- MEM_ADDR: A=01, B=10, ExtOp=1, ADD. → MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: waits for dmemReady, then → MEM_WB.
- MEM_WR: MemWrite=1 held until the dmemReady cycle inclusive, then → FETCH.
- MEM_WB: RegWrite=1, RegDst=00, MemtoReg=01. → FETCH.
- BRANCH: A=01, B=00, SUB, PCsrc=01; PCwrite=ALUzero. → FETCH.
- JUMP: PCwrite=1.
  - j: PCsrc=11.
  - jal: PCsrc=11, RegWrite=1, RegDst=JAL_REG, MemtoReg=10 (PC already holds PC+4).
  - jr: PCsrc=10.
  - → FETCH.
- Latency with ready signals tied high: R/ori/lui 4 cycles, lw 5, sw 4, beq 3, j/jal/jr 3, illegal 2.
- Each wait cycle adds exactly one cycle.
- Unreachable state codes (11-15) → FETCH next cycle with all enables 0.

Decomposition:
- Shared package mc_defs holds:
  - ALUctrl codes;
  - state codes;
  - opcode and funct constants;
  - ALUSrcA/ALUSrcB/PCsrc/RegDst/MemtoReg select codes;
  - the opClass enum: RTYPE, ORI, LUI, LW, SW, BEQ, J, JAL, JR, NOP.
- One combinational sub-module, mc_decode, maps opcode/funct to opClass and R-type ALUctrl. The FSM registers its output in DECODE.

Test Plan:
- addu (op 000000, funct 100001), readies high → states 0,1,2,8,0. ALUctrl=010 in EXEC_R; RegWrite=1 with RegDst=01 only in the 4th cycle.
- lw with dmemReady low for 3 cycles in MEM_RD → MEM_RD held 4 cycles. RegWrite=1, MemtoReg=01 exactly once; total 8 cycles.
- beq: ALUzero=1 → PCwrite=1, PCsrc=01 in BRANCH. Rerun with ALUzero=0 → PCwrite=0. Both return to FETCH after 3 cycles.
- lui → EXEC_I shows ALUSrcA=10, ALUctrl=101, ExtOp=0. ALU_WB has RegDst=00.
- opcode 111111 → illegal pulses 1 cycle in DECODE, next state FETCH, no RegWrite/MemWrite asserted.
- sw with reset asserted in MEM_WR (dmemReady=0) → next cycle state=0, MemWrite=0, IRwrite=0 while reset is high.
